disp_spi_sequencer: RTL and testbench

Byte sequencer sitting directly upstream of the display SPI master. Buffers command/data bytes from the capture/render logic in a small FIFO, launches them one at a time into the SPI master via its `start`/`data_in`/`done` handshake, and drives the display D/C pin so it is stable for the whole byte. Optionally plays a fixed power-on display init sequence before accepting user traffic.

---
 rtl/disp_spi_sequencer_if.sv | 26 ++
 rtl/disp_spi_sequencer.sv | 169 ++++++++++++++++
 tb/tb_disp_spi_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_spi_sequencer_if.sv
// Sequencer-facing bus: FIFO push side, status flags and the SPI master handshake.
// slave = the sequencer itself, master = the logic that feeds it and the SPI master.
interface disp_spi_sequencer_if;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_dc;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       busy;
   logic       init_done;
   logic       spi_start;
   logic [7:0] spi_data;
   logic       spi_done;
   logic       dc_out;

   modport slave (
      input  wr_en, wr_data, wr_dc, spi_done,
      output full, empty, overflow, busy, init_done, spi_start, spi_data, dc_out
   );

   modport master (
      output wr_en, wr_data, wr_dc, spi_done,
      input  full, empty, overflow, busy, init_done, spi_start, spi_data, dc_out
   );
endinterface

// File: rtl/disp_spi_sequencer.sv
// Byte FIFO + launch FSM feeding the display SPI master; D/C held for the whole byte.
// Define DISP_INIT_SEQ_EN to play the 6-byte power-on init ROM before user traffic.
module disp_spi_sequencer #(
   parameter int FIFO_AW    = 4,
   parameter int GAP_CYCLES = 2
) (
   input logic                 clk,
   input logic                 rst,
   disp_spi_sequencer_if.slave bus
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_LAUNCH, S_WAIT_DONE, S_GAP} state_e;

`ifdef DISP_INIT_SEQ_EN
   localparam state_e RST_STATE = S_INIT;
`else
   localparam state_e RST_STATE = S_IDLE;
`endif

   state_e            state_q, state_d;
   logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [8:0]        mem_q [DEPTH];
   logic [8:0]        head;
   logic              full, empty, push, pop;
   logic              overflow_q, overflow_d;
   logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
   logic [7:0]        spi_data_q, spi_data_d;
   logic              dc_q, dc_d;
   logic              xfer_end;
   logic              spi_start, busy;
   state_e            ret_state;

`ifdef DISP_INIT_SEQ_EN
   logic [2:0] init_idx_q, init_idx_d;
   logic       init_done_q, init_done_d;

   function automatic logic [7:0] rom_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    return 8'hAE;
         3'd1:    return 8'hD5;
         3'd2:    return 8'h80;
         3'd3:    return 8'h8D;
         3'd4:    return 8'h14;
         default: return 8'hAF;
      endcase
   endfunction
`endif

   // Flags come from registered pointers only, so a pop never frees a slot
   // for a push in the same cycle.
   assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign push  = bus.wr_en && !full;
   assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

   assign xfer_end = ((state_q == S_WAIT_DONE) && bus.spi_done && (GAP_CYCLES == 0)) ||
                     ((state_q == S_GAP) && (gap_cnt_q == '0));

`ifdef DISP_INIT_SEQ_EN
   assign ret_state = (!init_done_q && (init_idx_q != 3'd5)) ? S_INIT : S_IDLE;
`else
   assign ret_state = S_IDLE;
`endif

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= RST_STATE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:      if (!empty) state_d = S_LAUNCH;
         S_LAUNCH:    state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (bus.spi_done) state_d = (GAP_CYCLES > 0) ? S_GAP : ret_state;
         S_GAP:       if (gap_cnt_q == '0) state_d = ret_state;
`ifdef DISP_INIT_SEQ_EN
         S_INIT:      state_d = S_LAUNCH;
`endif
         default:     state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      spi_start = 1'b0;
      busy      = !empty;
      if (state_q == S_LAUNCH) spi_start = 1'b1;
      if (state_q != S_IDLE)   busy      = 1'b1;
   end

   always_comb begin
      pop        = (state_q == S_IDLE) && !empty;
      spi_data_d = spi_data_q;
      dc_d       = dc_q;
      gap_cnt_d  = gap_cnt_q;
      overflow_d = overflow_q | (bus.wr_en && full);
      wr_ptr_d   = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
      rd_ptr_d   = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};

      if (pop) {dc_d, spi_data_d} = head;
`ifdef DISP_INIT_SEQ_EN
      init_idx_d  = init_idx_q;
      init_done_d = init_done_q;
      if (state_q == S_INIT) {dc_d, spi_data_d} = {1'b0, rom_byte(init_idx_q)};
      if (xfer_end && !init_done_q) begin
         if (init_idx_q == 3'd5) init_done_d = 1'b1;
         else                    init_idx_d  = init_idx_q + 3'd1;
      end
`endif

      if ((state_q == S_WAIT_DONE) && bus.spi_done)
         gap_cnt_d = GAP_LOAD;
      else if ((state_q == S_GAP) && (gap_cnt_q != '0))
         gap_cnt_d = gap_cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         gap_cnt_q  <= '0;
         spi_data_q <= 8'h00;
         dc_q       <= 1'b0;
`ifdef DISP_INIT_SEQ_EN
         init_idx_q  <= 3'd0;
         init_done_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         gap_cnt_q  <= gap_cnt_d;
         spi_data_q <= spi_data_d;
         dc_q       <= dc_d;
`ifdef DISP_INIT_SEQ_EN
         init_idx_q  <= init_idx_d;
         init_done_q <= init_done_d;
`endif
      end
   end

   // Storage is not reset; a flush only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {bus.wr_dc, bus.wr_data};
   end

   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = busy;
   assign bus.spi_start = spi_start;
   assign bus.spi_data  = spi_data_q;
   assign bus.dc_out    = dc_q;
`ifdef DISP_INIT_SEQ_EN
   assign bus.init_done = init_done_q;
`else
   assign bus.init_done = 1'b1;
`endif

endmodule

// File: tb/tb_disp_spi_sequencer.sv
// Bench for disp_spi_sequencer: vector table, directed corner sequences and a
// randomized run against a queue-based scoreboard of the launch order.
module tb_disp_spi_sequencer;

   localparam int GAP   = 2;
   localparam int DEPTH = 16;
   localparam int L_GAP = 5;
`ifdef DISP_INIT_SEQ_EN
   localparam int ROM_N = 6;
   localparam bit MACRO = 1'b1;
`else
   localparam int ROM_N = 0;
   localparam bit MACRO = 1'b0;
`endif

   typedef struct {
      logic       dc;
      logic [7:0] data;
      int         lat;
      logic [7:0] exp_data;
      logic       exp_dc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   disp_spi_sequencer_if sif ();
   disp_spi_sequencer_if sif0 ();
   disp_spi_sequencer_if sif3 ();

   disp_spi_sequencer #(.FIFO_AW(4), .GAP_CYCLES(GAP)) dut  (.clk(clk), .rst(rst), .bus(sif));
   disp_spi_sequencer #(.FIFO_AW(4), .GAP_CYCLES(0))   dut0 (.clk(clk), .rst(rst), .bus(sif0));
   disp_spi_sequencer #(.FIFO_AW(4), .GAP_CYCLES(3))   dut3 (.clk(clk), .rst(rst), .bus(sif3));

   int         nvec = 0;
   int         nfail = 0;
   logic [7:0] rom [6];
   logic [8:0] q [$];
   int         cnt;
   bit         ovf_m;
   logic [7:0] last_d;
   logic       last_dc;
   int         rom_left;
   int         spi_lat = 2;
   bit         armed;
   int         spi_cnt;
   bit         done_pulsed;
   bit         stray = 1'b0;
   vec_t       tv [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      cnt      = 0;
      ovf_m    = 1'b0;
      last_d   = 8'h00;
      last_dc  = 1'b0;
      rom_left = ROM_N;
      armed    = 1'b0;
      spi_cnt  = 0;
   endtask

   // One clock: drive push + SPI-master response, then score everything visible.
   task automatic step(input bit we, input logic [7:0] d, input bit dc);
      bit         acc;
      logic [8:0] e;
      sif.wr_en    = we;
      sif.wr_data  = d;
      sif.wr_dc    = dc;
      sif.spi_done = stray;
      done_pulsed  = 1'b0;
      if (armed) begin
         if (spi_cnt == 0) begin
            sif.spi_done = 1'b1;
            armed        = 1'b0;
            done_pulsed  = 1'b1;
         end else spi_cnt--;
      end
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
         chk("rst_spi_start", sif.spi_start, 0);
      end else begin
         acc = we && (cnt < DEPTH);
         if (we && !acc) ovf_m = 1'b1;
         if (acc) begin
            q.push_back({dc, d});
            cnt++;
         end
         if (sif.spi_start) begin
            armed   = 1'b1;
            spi_cnt = spi_lat;
            e       = {last_dc, last_d};
            if (rom_left > 0) begin
               e = {1'b0, rom[ROM_N - rom_left]};
               rom_left--;
            end else if (q.size() > 0) begin
               e = q.pop_front();
               cnt--;
               chk("init_done_at_launch", sif.init_done, 1);
            end else chk("spurious_launch", sif.spi_start, 0);
            last_d  = e[7:0];
            last_dc = e[8];
         end
         if (rom_left > 0) chk("init_done_during_init", sif.init_done, 0);
      end
      chk("spi_data", sif.spi_data, last_d);
      chk("dc_out", sif.dc_out, last_dc);
      chk("full", sif.full, cnt == DEPTH);
      chk("empty", sif.empty, cnt == 0);
      chk("overflow", sif.overflow, ovf_m);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic drain(input int max);
      for (int i = 0; i < max; i++) begin
         if (q.size() == 0 && rom_left == 0 && !armed && !sif.busy) break;
         step(1'b0, 8'h00, 1'b0);
      end
      chk("drain_busy", sif.busy, 0);
      chk("drain_queue", q.size(), 0);
   endtask

   // GAP_CYCLES=0 and =3 instances run side by side with a fixed-latency responder.
   task automatic gap_test();
      int s0 [$];
      int s3 [$];
      int c0 = -1;
      int c3 = -1;
      int d0, d3;
      for (int t = 0; t < 300; t++) begin
         sif0.wr_en    = (t < 2);
         sif3.wr_en    = (t < 2);
         sif0.wr_data  = 8'h30 + 8'(t);
         sif3.wr_data  = 8'h30 + 8'(t);
         sif0.spi_done = (c0 == 0);
         sif3.spi_done = (c3 == 0);
         if (c0 >= 0) c0--;
         if (c3 >= 0) c3--;
         step(1'b0, 8'h00, 1'b0);
         if (sif0.spi_start) begin s0.push_back(t); c0 = L_GAP - 1; end
         if (sif3.spi_start) begin s3.push_back(t); c3 = L_GAP - 1; end
      end
      sif0.spi_done = 1'b0;
      sif3.spi_done = 1'b0;
      d0 = (s0.size() >= 2) ? s0[s0.size()-1] - s0[s0.size()-2] : -1;
      d3 = (s3.size() >= 2) ? s3[s3.size()-1] - s3[s3.size()-2] : -1;
      chk("gap0_launches", s0.size(), ROM_N + 2);
      chk("gap3_launches", s3.size(), ROM_N + 2);
      chk("gap0_spacing", d0, L_GAP + 1);
      chk("gap3_spacing", d3, L_GAP + 4);
      chk("gap_delta", d3 - d0, 3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rom = '{8'hAE, 8'hD5, 8'h80, 8'h8D, 8'h14, 8'hAF};
      tv[0] = '{1'b1, 8'hA5, 23, 8'hA5, 1'b1};
      tv[1] = '{1'b0, 8'h21, 3,  8'h21, 1'b0};
      tv[2] = '{1'b1, 8'h7F, 5,  8'h7F, 1'b1};
      tv[3] = '{1'b0, 8'h22, 1,  8'h22, 1'b0};
      sif.wr_en = 1'b0; sif.wr_data = 8'h00; sif.wr_dc = 1'b0; sif.spi_done = 1'b0;
      sif0.wr_en = 1'b0; sif0.wr_data = 8'h00; sif0.wr_dc = 1'b0; sif0.spi_done = 1'b0;
      sif3.wr_en = 1'b0; sif3.wr_data = 8'h00; sif3.wr_dc = 1'b0; sif3.spi_done = 1'b0;
      model_reset();

      // Reset values
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      chk("rst_busy", sif.busy, MACRO);
      chk("rst_init_done", sif.init_done, !MACRO);

      gap_test();

      // Fresh reset, byte pushed immediately (during INIT when the ROM is present)
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      step(1'b1, 8'h5A, 1'b1);
      drain(400);
      chk("init_done_final", sif.init_done, 1);

      // Vector table: one byte each, launch latency, D/C hold, busy gap after done
      for (int i = 0; i < 4; i++) begin
         spi_lat = tv[i].lat;
         step(1'b1, tv[i].data, tv[i].dc);
         step(1'b0, 8'h00, 1'b0);
         chk("tv_start", sif.spi_start, 1);
         chk("tv_data", sif.spi_data, tv[i].exp_data);
         chk("tv_dc", sif.dc_out, tv[i].exp_dc);
         for (int k = 0; k < 100 && !done_pulsed; k++) step(1'b0, 8'h00, 1'b0);
         chk("tv_dc_hold", sif.dc_out, tv[i].exp_dc);
         chk("tv_data_hold", sif.spi_data, tv[i].exp_data);
         n = 0;
         while (sif.busy && n < 50) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
         end
         chk("tv_busy_gap", n, GAP);
      end

      // Fill to full behind a stalled byte, then overflow on the 17th push
      spi_lat = 60;
      step(1'b1, 8'hEE, 1'b1);
      for (int b = 0; b < 16; b++) step(1'b1, 8'(b), 1'b0);
      chk("full_after_16", sif.full, 1);
      chk("ovf_before_17", sif.overflow, 0);
      step(1'b1, 8'h10, 1'b1);
      chk("ovf_after_17", sif.overflow, 1);
      spi_lat = 2;
      drain(1000);
      chk("ovf_sticky", sif.overflow, 1);

      // Randomized traffic and SPI latency, light then heavy load
      for (int c = 0; c < 1200; c++) begin
         spi_lat = $urandom_range(1, 6);
         step(($urandom_range(0, 99) < ((c < 600) ? 10 : 45)), 8'($urandom), 1'($urandom));
      end
      spi_lat = 2;
      drain(1000);

      // Reset while a byte is in flight with 5 more queued; then a stray done
      spi_lat = 40;
      for (int k = 0; k < 6; k++) step(1'b1, 8'hC0 + 8'(k), k[0]);
      chk("pre_rst_queued", sif.empty, 0);
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      chk("rst_mid_empty", sif.empty, 1);
      chk("rst_mid_start", sif.spi_start, 0);
      chk("rst_mid_ovf", sif.overflow, 0);
      stray = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      stray = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 8'h00, 1'b0);
         chk("rst_mid_busy", sif.busy, MACRO);
      end
      spi_lat = 2;
      drain(1000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
